fb_port_arbiter: RTL
====================

Name: fb_port_arbiter

Overview:
Shares the single-port frame-buffer RAM (NUM_PIXELS x DATA_W, registered output) between two requesters:
- the UART pixel writer, which cannot stall;
- the VGA pixel reader, which must never miss a slot.

Reads have absolute priority. Writes are held in a small FIFO and drained into idle RAM cycles. The block owns the write-address counter and frame wrap, and sits between the UART receive path, the VGA read path and the RAM macro, entirely in clk_sys.

Parameters:
ADDR_W, 19, RAM address width
DATA_W, 3, pixel (palette index) width
NUM_PIXELS, 307200, frame size in pixels (640*480); write address wraps at NUM_PIXELS-1
FIFO_DEPTH, 8, write FIFO depth, power of two, >= 2
RAM_LATENCY, 2, cycles from ram_addr valid to ram_q valid
CNT_W, 16, width of overflow counter

Ports:
clk_sys  in  1  system clock
rst_n  in  1  synchronous active-low reset
wr_valid  in  1  one-cycle pixel strobe from UART path
wr_data  in  DATA_W  pixel value
wr_ready  out  1  FIFO not full (informational; writer does not stall)
frame_start  in  1  restart write address at 0, flush FIFO
rd_req  in  1  VGA read request, synchronous to clk_sys
rd_addr  in  ADDR_W  VGA read address
rd_valid  out  1  rd_data valid
rd_data  out  DATA_W  read pixel
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_we  out  1  RAM write enable (registered)
ram_q  in  DATA_W  RAM read data
frame_done  out  1  one-cycle pulse when write to address NUM_PIXELS-1 is issued
overflow_cnt  out  CNT_W  dropped-pixel count, saturating
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at a clk_sys edge):
  - all outputs 0, except wr_ready=1;
  - write pointer 0, FIFO empty, read pipeline cleared;
  - reset mid-operation discards in-flight reads and queued writes, with no rd_valid afterwards.
- Write accept:
  - wr_valid=1 with FIFO not full: push wr_data.
  - wr_valid=1 with FIFO full: beat dropped; overflow_cnt += 1, saturating at all-ones.
  - Simultaneous pop and push on a full FIFO is still a drop, because fullness is evaluated before the pop.
- Per-cycle issue decision, registered onto ram_* at the next edge:
  - rd_req=1: READ issue. ram_addr<=rd_addr, ram_we<=0.
  - else if FIFO not empty: WRITE issue. Pop head; ram_addr<=wptr, ram_wdata<=head, ram_we<=1; wptr advances.
  - else: IDLE. ram_we<=0; ram_addr holds.
- Latency:
  - A pixel accepted at cycle N is popped no earlier than N+1 (non-fall-through FIFO), so ram_we rises no earlier than N+2.
  - rd_req at cycle N gives ram_addr at N+1 and rd_valid=1 with rd_data=ram_q at N+1+RAM_LATENCY (=N+3 by default). This uses a RAM_LATENCY-deep valid shift register.
  - Back-to-back reads give back-to-back rd_valid.
- Write pointer:
  - Increments on each WRITE issue.
  - At NUM_PIXELS-1 it wraps to 0, and frame_done pulses in the same cycle ram_we carries that write.
- frame_start:
  - Flushes the FIFO and sets wptr=0; queued pixels are discarded and not counted as overflow.
  - If wr_valid is high in the same cycle, that beat is pushed into the emptied FIFO and lands at address 0.
  - No WRITE is issued in the frame_start cycle.
  - Reads are unaffected.
- fifo_level and wr_ready reflect state after the current edge's push/pop.
- overflow_cnt is cleared only by reset.

Decomposition:
- Package fb_arb_pkg: issue enum {ISSUE_IDLE, ISSUE_READ, ISSUE_WRITE}; default frame constants (H_PIXELS=640, V_PIXELS=480, NUM_PIXELS); DATA_W.
- Sub-module fb_wr_fifo: synchronous FIFO with push, pop, flush, full, empty, level.
- The arbiter, write pointer, read pipeline and counters live in the top.

Test Plan:
- Reset, then 3 pixels 5,2,7 with rd_req=0 -> ram_we pulses with (addr,data) = (0,5),(1,2),(2,7); first ram_we 2 cycles after first wr_valid; overflow_cnt=0.
- rd_req held for 30 cycles, rd_addr=100..129, with 6 pixels injected -> no ram_we during reads; rd_valid at cycles 3..32 carrying ram_q for each address in order; fifo_level=6; after rd_req drops, 6 consecutive writes to addresses 0..5 in order.
- FIFO_DEPTH=8, rd_req held, 12 pixels -> 8 queued, overflow_cnt=4, wr_ready=0 after the 8th; after drain, exactly 8 writes, wr_ready=1.
- NUM_PIXELS=16, 18 pixels without reads -> addresses 0..15, then 0,1; frame_done pulses once, coincident with the write to 15.
- frame_start after 5 of 10 queued pixels, with wr_valid same cycle, data=3 -> remaining queue discarded; next write is (0,3); overflow_cnt unchanged.
- rst_n low for 1 cycle with 4 reads in flight and 3 pixels queued -> no rd_valid and no ram_we afterwards; all outputs at reset values.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and default frame geometry for the frame-buffer port arbiter.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_READ  = 2'd1,
    ISSUE_WRITE = 2'd2
  } issue_e;

  localparam int H_PIXELS      = 640;
  localparam int V_PIXELS      = 480;
  localparam int FB_NUM_PIXELS = H_PIXELS * V_PIXELS;
  localparam int FB_DATA_W     = 3;

endpackage

// File: rtl/fb_wr_fifo.sv
// Non-fall-through write FIFO; flush empties it and may accept a push in the same cycle.
module fb_wr_fifo #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign level     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  // A flush always makes room for the same-cycle push.
  assign do_push_s = push && (flush || !full);
  assign do_pop_s  = pop && !empty && !flush;

  // pointer and occupancy update
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= do_push_s ? PTR_W'(1) : {PTR_W{1'b0}};
      count_r  <= do_push_s ? (PTR_W+1)'(1) : {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // storage write
  always_ff @(posedge clk_sys) begin
    if (do_push_s) begin
      mem_r[flush ? {PTR_W{1'b0}} : wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads always win, UART pixels queue and drain into idle RAM slots.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = FB_DATA_W,
  parameter int NUM_PIXELS  = FB_NUM_PIXELS,
  parameter int FIFO_DEPTH  = 8,
  parameter int RAM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  input  logic                          frame_start,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_q,
  output logic                          frame_done,
  output logic [CNT_W-1:0]              overflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  issue_e                issue_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [DATA_W-1:0]     fifo_head_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;
  logic                  wptr_last_s;
  logic [ADDR_W-1:0]     wptr_r;
  logic [ADDR_W-1:0]     ram_addr_r;
  logic [DATA_W-1:0]     ram_wdata_r;
  logic                  ram_we_r;
  logic                  ram_re_r;
  logic                  frame_done_r;
  logic [RAM_LATENCY-1:0] rd_pipe_r;
  logic [CNT_W-1:0]      overflow_r;

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO drops.
  assign push_s      = wr_valid && (frame_start || !fifo_full_s);
  assign drop_s      = wr_valid && !frame_start && fifo_full_s;
  assign pop_s       = (issue_s == ISSUE_WRITE);
  assign wptr_last_s = (wptr_r == ADDR_W'(NUM_PIXELS - 1));

  fb_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (frame_start),
    .din     (wr_data),
    .dout    (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  // per-cycle RAM slot owner
  always_comb begin
    issue_s = ISSUE_IDLE;
    if (rd_req) begin
      issue_s = ISSUE_READ;
    end else if (!fifo_empty_s && !frame_start) begin
      issue_s = ISSUE_WRITE;
    end else begin
      issue_s = ISSUE_IDLE;
    end
  end

  // RAM command register; ram_addr and ram_wdata hold while idle
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      ram_addr_r   <= {ADDR_W{1'b0}};
      ram_wdata_r  <= {DATA_W{1'b0}};
      ram_we_r     <= 1'b0;
      ram_re_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      case (issue_s)
        ISSUE_READ: begin
          ram_addr_r   <= rd_addr;
          ram_we_r     <= 1'b0;
          ram_re_r     <= 1'b1;
          frame_done_r <= 1'b0;
        end
        ISSUE_WRITE: begin
          ram_addr_r   <= wptr_r;
          ram_wdata_r  <= fifo_head_s;
          ram_we_r     <= 1'b1;
          ram_re_r     <= 1'b0;
          frame_done_r <= wptr_last_s;
        end
        default: begin
          ram_we_r     <= 1'b0;
          ram_re_r     <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  // write pointer with frame wrap
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wptr_r <= {ADDR_W{1'b0}};
    end else if (frame_start) begin
      wptr_r <= {ADDR_W{1'b0}};
    end else if (issue_s == ISSUE_WRITE) begin
      wptr_r <= wptr_last_s ? {ADDR_W{1'b0}} : wptr_r + ADDR_W'(1);
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // read-valid shift register tracking the RAM pipeline
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      rd_pipe_r <= {RAM_LATENCY{1'b0}};
    end else begin
      rd_pipe_r[0] <= ram_re_r;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  // saturating dropped-pixel counter, cleared only by reset
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      overflow_r <= {CNT_W{1'b0}};
    end else if (drop_s && (overflow_r != {CNT_W{1'b1}})) begin
      overflow_r <= overflow_r + CNT_W'(1);
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign ram_addr     = ram_addr_r;
  assign ram_wdata    = ram_wdata_r;
  assign ram_we       = ram_we_r;
  assign frame_done   = frame_done_r;
  assign overflow_cnt = overflow_r;
  assign wr_ready     = !fifo_full_s;
  assign rd_valid     = rd_pipe_r[RAM_LATENCY-1];
  // ram_q is already the registered macro output; gate it so rd_data is 0 when not valid.
  assign rd_data      = rd_valid ? ram_q : {DATA_W{1'b0}};

endmodule
